// File: rtl/cs_round_iter.sv
// cs_round_iter: iterative CS-Cipher encryption of one 64-bit block.
// One E mixing step per clock, 3 steps per round, then a whitening XOR.
// Round keys are fetched from an external store via key_idx/key_in.
// Optional trace outputs are enabled with the macro CS_ROUND_TRACE_EN.

// m_module: 16-bit CS-Cipher M mixing function built on the 8-bit P box.
module m_module (
  input  logic [15:0] x,
  output logic [15:0] y
);
  function automatic logic [3:0] f_box(input logic [3:0] n);
    logic [3:0] v;
    case (n)
      4'h0: v = 4'hf; 4'h1: v = 4'hd; 4'h2: v = 4'hb; 4'h3: v = 4'hb;
      4'h4: v = 4'h7; 4'h5: v = 4'h5; 4'h6: v = 4'h7; 4'h7: v = 4'h7;
      4'h8: v = 4'he; 4'h9: v = 4'hd; 4'ha: v = 4'ha; 4'hb: v = 4'hb;
      4'hc: v = 4'he; 4'hd: v = 4'hd; 4'he: v = 4'he; default: v = 4'hf;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] g_box(input logic [3:0] n);
    logic [3:0] v;
    case (n)
      4'h0: v = 4'ha; 4'h1: v = 4'h6; 4'h2: v = 4'h0; 4'h3: v = 4'h2;
      4'h4: v = 4'hb; 4'h5: v = 4'he; 4'h6: v = 4'h1; 4'h7: v = 4'h8;
      4'h8: v = 4'hd; 4'h9: v = 4'h4; 4'ha: v = 4'h5; 4'hb: v = 4'h3;
      4'hc: v = 4'hf; 4'hd: v = 4'hc; 4'he: v = 4'h7; default: v = 4'h9;
    endcase
    return v;
  endfunction

  // Three-layer Feistel-like nibble network.
  function automatic logic [7:0] p_box(input logic [7:0] a);
    logic [3:0] t_y, t_z, t_t;
    t_y = a[3:0] ^ f_box(a[7:4]);
    t_z = a[7:4] ^ g_box(t_y);
    t_t = t_y ^ f_box(t_z);
    return {t_z, t_t};
  endfunction

  logic [7:0] xl, xr, rot_l, phi_l;

  assign xl    = x[15:8];
  assign xr    = x[7:0];
  assign rot_l = {xl[6:0], xl[7]};
  assign phi_l = (rot_l & 8'h55) ^ xl;
  assign y     = {p_box(phi_l ^ xr), p_box(rot_l ^ xr)};
endmodule

module cs_round_iter #(
  parameter logic [63:0] C0      = 64'hB7E151628AED2A6A,
  parameter logic [63:0] C1      = 64'hBF7158809CF4F3C7,
  parameter int          NROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [3:0]  key_idx,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
`ifdef CS_ROUND_TRACE_EN
  ,
  output logic [63:0] dbg_state,
  output logic [4:0]  dbg_step,
  output logic        dbg_valid
`endif
);
  localparam logic [3:0] LAST_R = 4'(NROUNDS - 1);
  localparam logic [3:0] NR     = 4'(NROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] s_q, s_d;
  logic [3:0]  r_q, r_d;
  logic [1:0]  sub_q, sub_d;
  logic [3:0]  key_idx_q, key_idx_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [63:0] e_in, e_out;
  logic [15:0] m_out [4];

  // Select the pre-mix value for the current substep.
  always_comb begin
    case (sub_q)
      2'd0:    e_in = s_q ^ key_in ^ C0;
      2'd1:    e_in = s_q ^ C1;
      default: e_in = s_q;
    endcase
  end

  // E layer: four M boxes, high bytes gathered in the upper half.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    m_module u_m (
      .x(e_in[16*gi +: 16]),
      .y(m_out[gi])
    );
    assign e_out[32 + 8*gi +: 8] = m_out[gi][15:8];
    assign e_out[8*gi +: 8]      = m_out[gi][7:0];
  end

  // Next-state logic: accept, iterate E steps, whiten, hand off.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    r_d         = r_q;
    sub_d       = sub_q;
    key_idx_d   = key_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        key_idx_d = 4'd0;
        if (in_valid) begin
          s_d     = in_data;
          r_d     = 4'd0;
          sub_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = e_out;
        if (sub_q == 2'd2) begin
          sub_d     = 2'd0;
          r_d       = r_q + 4'd1;
          key_idx_d = r_q + 4'd1;
          if (r_q == LAST_R) begin
            r_d       = NR;
            key_idx_d = NR;
            state_d   = DONE;
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_data_d  = s_q ^ key_in;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          r_d         = 4'd0;
          sub_d       = 2'd0;
          key_idx_d   = 4'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= 64'd0;
      r_q         <= 4'd0;
      sub_q       <= 2'd0;
      key_idx_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      r_q         <= r_d;
      sub_q       <= sub_d;
      key_idx_q   <= key_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign key_idx   = key_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef CS_ROUND_TRACE_EN
  logic [4:0] dbg_step_q, dbg_step_d;
  logic       dbg_valid_q, dbg_valid_d;

  // Trace: report the index of the step that just updated s.
  always_comb begin
    dbg_valid_d = (state_q == RUN);
    dbg_step_d  = dbg_step_q;
    if (state_q == RUN) begin
      dbg_step_d = 5'({1'b0, r_q}) * 5'd3 + {3'b000, sub_q};
    end
  end

  // Trace registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_step_q  <= 5'd0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_step_q  <= dbg_step_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  assign dbg_state = s_q;
  assign dbg_step  = dbg_step_q;
  assign dbg_valid = dbg_valid_q;
`endif
endmodule
